// File: rtl/pixel_pkg.sv
// Shared types, colour constants and geometry helpers for the breakout pixel renderer.
package pixel_pkg;

    localparam int unsigned COORD_W = 10;
    localparam int unsigned SUM_W   = COORD_W + 1;
    localparam int unsigned CH_W    = 8;
    localparam int unsigned RGB_W   = 3 * CH_W;

    typedef struct packed {
        logic [CH_W-1:0] r;
        logic [CH_W-1:0] g;
        logic [CH_W-1:0] b;
    } rgb_t;

    localparam rgb_t COL_BLACK  = rgb_t'(24'h000000);
    localparam rgb_t COL_PADDLE = rgb_t'(24'h00FF00);
    localparam rgb_t COL_BALL   = rgb_t'(24'hFF0000);
    localparam rgb_t COL_FLASH  = rgb_t'(24'hFFFFFF);

    // Five row colours, row 0 in the LSBs.
    localparam logic [5*RGB_W-1:0] DEF_ROW_COLORS =
        {24'h2060D0, 24'h20A020, 24'hC0C020, 24'hD08020, 24'hC03030};

    // Inclusive-low, exclusive-high span test; the high edge is formed one bit wider so it never wraps.
    function automatic logic span_hit(input logic [COORD_W-1:0] pos,
                                      input logic [COORD_W-1:0] lo,
                                      input int unsigned        size);
        logic [SUM_W-1:0] hi;
        hi = SUM_W'(lo) + SUM_W'(size);
        return (pos >= lo) && (SUM_W'(pos) < hi);
    endfunction

    // Cell index along one axis by comparing against constant cell boundaries.
    function automatic int unsigned grid_index(input logic [COORD_W-1:0] pos,
                                               input int unsigned        origin,
                                               input int unsigned        size,
                                               input int unsigned        count);
        int unsigned idx;
        idx = 0;
        for (int unsigned i = 1; i < count; i++) begin
            if (32'(pos) >= origin + i * size) idx = i;
        end
        return idx;
    endfunction

    function automatic int unsigned brick_bit(input int unsigned row,
                                              input int unsigned col,
                                              input int unsigned cols);
        return row * cols + col;
    endfunction

endpackage

// File: rtl/pixel_pipeline_if.sv
// Game-state and VGA signal bundle between the timing/game logic and the pixel renderer.
interface pixel_pipeline_if #(
    parameter int unsigned N_BALLS  = 1,
    parameter int unsigned N_BRICKS = 50
);
    import pixel_pkg::*;

    logic                         frame_start;
    logic                         video_on;
    logic [COORD_W-1:0]           x;
    logic [COORD_W-1:0]           y;
    logic [COORD_W-1:0]           paddle_x;
    logic [COORD_W-1:0]           paddle_y;
    logic [COORD_W*N_BALLS-1:0]   ball_x;
    logic [COORD_W*N_BALLS-1:0]   ball_y;
    logic [N_BRICKS-1:0]          brick_state;
    logic [CH_W-1:0]              VGA_R;
    logic [CH_W-1:0]              VGA_G;
    logic [CH_W-1:0]              VGA_B;
    logic                         video_on_out;

    modport master (
        output frame_start, video_on, x, y, paddle_x, paddle_y, ball_x, ball_y, brick_state,
        input  VGA_R, VGA_G, VGA_B, video_on_out
    );

    modport slave (
        input  frame_start, video_on, x, y, paddle_x, paddle_y, ball_x, ball_y, brick_state,
        output VGA_R, VGA_G, VGA_B, video_on_out
    );

endinterface

// File: rtl/brick_flash_ctrl.sv
// Per-frame brick snapshot plus per-brick flash counters (built only with PIXEL_HIT_FLASH_EN).
module brick_flash_ctrl #(
    parameter int unsigned N_BRICKS     = 50,
    parameter int unsigned FLASH_FRAMES = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                frame_start,
    input  logic [N_BRICKS-1:0] brick_state,
    output logic [N_BRICKS-1:0] snap,
    output logic [N_BRICKS-1:0] flashing
);

    // Brick map is only ever sampled at the frame boundary so a frame never tears.
    always_ff @(posedge clk) begin
        if (rst) begin
            snap <= '0;
        end else if (frame_start) begin
            snap <= brick_state;
        end
    end

`ifdef PIXEL_HIT_FLASH_EN
    localparam int unsigned CNT_W = $clog2(FLASH_FRAMES + 1);

    logic [CNT_W-1:0] cnt [N_BRICKS];

    // A brick dying this frame reloads its counter; otherwise live counters run down once per frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_BRICKS; i++) cnt[i] <= '0;
            flashing <= '0;
        end else if (frame_start) begin
            for (int i = 0; i < N_BRICKS; i++) begin
                if (snap[i] && !brick_state[i]) begin
                    cnt[i]      <= CNT_W'(FLASH_FRAMES);
                    flashing[i] <= 1'b1;
                end else if (cnt[i] != '0) begin
                    cnt[i]      <= cnt[i] - 1'b1;
                    flashing[i] <= (cnt[i] != CNT_W'(1));
                end
            end
        end
    end
`else
    assign flashing = '0;
`endif

endmodule

// File: rtl/pixel_pipeline.sv
// Two-stage registered breakout pixel renderer: paddle, balls and a snapshot brick field.
// Optional white flash on destroyed bricks when PIXEL_HIT_FLASH_EN is defined.
module pixel_pipeline
    import pixel_pkg::*;
#(
    parameter int unsigned N_BALLS       = 1,
    parameter int unsigned PADDLE_WIDTH  = 64,
    parameter int unsigned PADDLE_HEIGHT = 8,
    parameter int unsigned BALL_SIZE     = 6,
    parameter int unsigned BRICK_ROWS    = 5,
    parameter int unsigned BRICK_COLS    = 10,
    parameter int unsigned BRICK_WIDTH   = 60,
    parameter int unsigned BRICK_HEIGHT  = 18,
    parameter int unsigned BRICK_X0      = 20,
    parameter int unsigned BRICK_Y0      = 40,
    parameter logic [RGB_W*BRICK_ROWS-1:0] ROW_COLORS = DEF_ROW_COLORS,
    parameter int unsigned FLASH_FRAMES  = 6
) (
    input logic             clk,
    input logic             rst,
    pixel_pipeline_if.slave bus
);

    localparam int unsigned N_BRICKS = BRICK_ROWS * BRICK_COLS;
    localparam int unsigned FIELD_W  = BRICK_COLS * BRICK_WIDTH;
    localparam int unsigned FIELD_H  = BRICK_ROWS * BRICK_HEIGHT;
    localparam int unsigned ROW_W    = (BRICK_ROWS > 1) ? $clog2(BRICK_ROWS) : 1;
    localparam int unsigned COL_W    = (BRICK_COLS > 1) ? $clog2(BRICK_COLS) : 1;
    localparam int unsigned BIDX_W   = (N_BRICKS > 1) ? $clog2(N_BRICKS) : 1;

    logic [N_BRICKS-1:0] snap;
    logic [N_BRICKS-1:0] flashing;

    brick_flash_ctrl #(
        .N_BRICKS     (N_BRICKS),
        .FLASH_FRAMES (FLASH_FRAMES)
    ) u_flash (
        .clk         (clk),
        .rst         (rst),
        .frame_start (bus.frame_start),
        .brick_state (bus.brick_state),
        .snap        (snap),
        .flashing    (flashing)
    );

    // Stage 1: geometry hit tests.
    logic             paddle_hit_c;
    logic             ball_hit_c;
    logic             field_hit_c;
    logic [ROW_W-1:0] row_c;
    logic [COL_W-1:0] col_c;

    always_comb begin
        paddle_hit_c = span_hit(bus.x, bus.paddle_x, PADDLE_WIDTH) &&
                       span_hit(bus.y, bus.paddle_y, PADDLE_HEIGHT);
        ball_hit_c   = 1'b0;
        for (int i = 0; i < N_BALLS; i++) begin
            if (span_hit(bus.x, bus.ball_x[COORD_W*i +: COORD_W], BALL_SIZE) &&
                span_hit(bus.y, bus.ball_y[COORD_W*i +: COORD_W], BALL_SIZE)) begin
                ball_hit_c = 1'b1;
            end
        end
        field_hit_c  = span_hit(bus.x, COORD_W'(BRICK_X0), FIELD_W) &&
                       span_hit(bus.y, COORD_W'(BRICK_Y0), FIELD_H);
        row_c        = ROW_W'(grid_index(bus.y, BRICK_Y0, BRICK_HEIGHT, BRICK_ROWS));
        col_c        = COL_W'(grid_index(bus.x, BRICK_X0, BRICK_WIDTH, BRICK_COLS));
    end

    logic             s1_video_on;
    logic             s1_paddle;
    logic             s1_ball;
    logic             s1_field;
    logic [ROW_W-1:0] s1_row;
    logic [COL_W-1:0] s1_col;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_video_on <= 1'b0;
            s1_paddle   <= 1'b0;
            s1_ball     <= 1'b0;
            s1_field    <= 1'b0;
            s1_row      <= '0;
            s1_col      <= '0;
        end else begin
            s1_video_on <= bus.video_on;
            s1_paddle   <= paddle_hit_c;
            s1_ball     <= ball_hit_c;
            s1_field    <= field_hit_c;
            s1_row      <= row_c;
            s1_col      <= col_c;
        end
    end

    // Stage 2: brick lookup and layer priority.
    rgb_t row_rgb [BRICK_ROWS];

    for (genvar r = 0; r < BRICK_ROWS; r++) begin : g_row_rgb
        assign row_rgb[r] = rgb_t'(ROW_COLORS[RGB_W*r +: RGB_W]);
    end

    logic [BIDX_W-1:0] brick_idx_c;
    rgb_t              colour_c;

    always_comb begin
        brick_idx_c = BIDX_W'(brick_bit(32'(s1_row), 32'(s1_col), BRICK_COLS));
        colour_c    = COL_BLACK;
        if (s1_video_on) begin
            if (s1_paddle) begin
                colour_c = COL_PADDLE;
            end else if (s1_ball) begin
                colour_c = COL_BALL;
            end else if (s1_field && flashing[brick_idx_c]) begin
                colour_c = COL_FLASH;
            end else if (s1_field && snap[brick_idx_c]) begin
                colour_c = row_rgb[s1_row];
            end
        end
    end

    rgb_t pix;
    logic s2_video_on;

    always_ff @(posedge clk) begin
        if (rst) begin
            pix         <= COL_BLACK;
            s2_video_on <= 1'b0;
        end else begin
            pix         <= colour_c;
            s2_video_on <= s1_video_on;
        end
    end

    assign bus.VGA_R        = pix.r;
    assign bus.VGA_G        = pix.g;
    assign bus.VGA_B        = pix.b;
    assign bus.video_on_out = s2_video_on;

endmodule
